// File: rtl/uart_receiver_if.sv
// uart_receiver_if: serial-side inputs and received-byte outputs of the UART receiver.
// Latency: none, wiring only.
// Backpressure: none; rx_done_tick is a one-clk strobe the consumer must take when it fires.
// Signals: rx, s_tick (into the receiver); dout, rx_done_tick, frame_err, parity_err (out of it).
interface uart_receiver_if;
  logic       rx;
  logic       s_tick;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       parity_err;

  // master: whoever drives the line and the baud strobe and consumes the byte
  modport master (
    output rx, s_tick,
    input  dout, rx_done_tick, frame_err, parity_err
  );

  // slave: the receiver itself
  modport slave (
    input  rx, s_tick,
    output dout, rx_done_tick, frame_err, parity_err
  );
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampling UART receiver, LSB-first, DBIT data bits, optional parity
//   (parity state and parity_err only when UART_RX_PARITY_EN is defined; otherwise parity_err = 0).
// Latency: rx_done_tick one clk after the mid-stop-bit s_tick; 2-clk synchronizer on rx.
// Backpressure: none; dout/frame_err/parity_err hold until the next frame completes.
// Ports: clk, reset_n (async, active low); bus.slave carries rx, s_tick in and
//   dout, rx_done_tick, frame_err, parity_err out.
module uart_receiver #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic           clk,
  input  logic           reset_n,
  uart_receiver_if.slave bus
);

  // Stop bit can last up to 32 ticks (2 stop bits), which needs a 5-bit counter.
  localparam int SW    = (SB_TICK > 16) ? 5 : 4;
  // Data lands in the top DBIT bits of the shift register; this right-aligns it.
  localparam int SHIFT = 8 - DBIT;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            rx_meta_q, rx_meta_d;
  logic            rx_s_q, rx_s_d;
  logic [SW-1:0]   s_q, s_d;
  logic [2:0]      n_q, n_d;
  logic [7:0]      b_q, b_d;
  logic [7:0]      dout_q, dout_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_SENSE = (PARITY_ODD != 0);
  logic            par_bit_q, par_bit_d;
  logic            perr_q, perr_d;
`endif

  always_comb begin
    rx_meta_d = bus.rx;
    rx_s_d    = rx_meta_q;
    state_d   = state_q;
    s_d       = s_q;
    n_d       = n_q;
    b_d       = b_q;
    dout_d    = dout_q;
    done_d    = 1'b0;
    ferr_d    = ferr_q;
`ifdef UART_RX_PARITY_EN
    par_bit_d = par_bit_q;
    perr_d    = perr_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          state_d = ST_START;
          s_d     = '0;
        end
      end

      ST_START: begin
        if (bus.s_tick) begin
          if (s_q == SW'(7)) begin
            // Re-check the line at mid start bit; a high line here was a glitch.
            if (!rx_s_q) begin
              state_d = ST_DATA;
              n_d     = '0;
            end else begin
              state_d = ST_IDLE;
            end
            s_d = '0;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      ST_DATA: begin
        if (bus.s_tick) begin
          if (s_q == SW'(15)) begin
            b_d = {rx_s_q, b_q[7:1]};
            s_d = '0;
            if (n_q == 3'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (bus.s_tick) begin
          if (s_q == SW'(15)) begin
            par_bit_d = rx_s_q;
            s_d       = '0;
            state_d   = ST_STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`endif

      ST_STOP: begin
        if (bus.s_tick) begin
          if (s_q == SW'(SB_TICK - 1)) begin
            // Returning to idle here (not at end of stop) lets a back-to-back
            // start edge be caught during the second half of the stop bit.
            state_d = ST_IDLE;
            s_d     = '0;
            dout_d  = b_q >> SHIFT;
            ferr_d  = ~rx_s_q;
            done_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d  = (^(b_q >> SHIFT)) ^ par_bit_q ^ PAR_SENSE;
`endif
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        s_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      s_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      s_q       <= s_d;
      n_q       <= n_d;
      b_q       <= b_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= par_bit_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign bus.dout         = dout_q;
  assign bus.rx_done_tick = done_q;
  assign bus.frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err   = perr_q;
`else
  assign bus.parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames into uart_receiver (8 data bits, 1 stop, s_tick every 4 clk).
// Latency: one bit time is 64 clk; rx_done_tick expected near mid stop bit.
// Backpressure: none; a negedge monitor records every rx_done_tick with its dout.
module tb_uart_receiver;
  localparam int BIT_CLK = 64;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif
  // Start edge to mid-stop in line time: 9.5 bits, plus one bit with parity.
  localparam int MID_STOP = PAR_ON ? 672 : 608;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  uart_receiver_if bus();

  uart_receiver #(.DBIT(8), .SB_TICK(16), .PARITY_ODD(0)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int last_tick_cyc = 0;
  int frame_start = 0;
  logic [7:0] rec_q[$];

  always @(negedge clk) begin
    if (bus.rx_done_tick) begin
      done_cnt++;
      last_tick_cyc = cyc;
      rec_q.push_back(bus.dout);
    end
  end

  // s_tick: one clk high every 4 clk
  initial begin
    bus.s_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      bus.s_tick = 1'b1;
      @(negedge clk);
      bus.s_tick = 1'b0;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_bits(input int nb);
    bus.rx = 1'b1;
    repeat (nb * BIT_CLK) @(negedge clk);
  endtask

  // One frame; a low stop bit is held low for 3/4 bit so the receiver's
  // early return to idle sees the line high again by its mid-start check.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_b);
    frame_start = cyc;
    bus.rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    if (PAR_ON) begin
      bus.rx = par_b;
      repeat (BIT_CLK) @(negedge clk);
    end
    if (stop_v) begin
      bus.rx = 1'b1;
      repeat (BIT_CLK) @(negedge clk);
    end else begin
      bus.rx = 1'b0;
      repeat (48) @(negedge clk);
      bus.rx = 1'b1;
      repeat (16) @(negedge clk);
    end
  endtask

  initial begin
    int base;
    int off;
    int got;
    logic [7:0] exp_b2b [3];
    exp_b2b[0] = 8'h00;
    exp_b2b[1] = 8'hFF;
    exp_b2b[2] = 8'h81;

    bus.rx  = 1'b1;
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // reset held, then released with an idle line
    repeat (8) @(negedge clk);
    reset_n = 1'b1;
    idle_bits(2);
    chk("rst_dout", bus.dout, 8'h00);
    chk("rst_ticks", done_cnt, 0);
    chk("rst_ferr", bus.frame_err, 0);
    chk("rst_perr", bus.parity_err, 0);

    // 0xA5, good stop
    base = done_cnt;
    send_frame(8'hA5, 1'b1, ^8'hA5);
    idle_bits(1);
    chk("a5_ticks", done_cnt - base, 1);
    chk("a5_dout", bus.dout, 8'hA5);
    chk("a5_ferr", bus.frame_err, 0);
    chk("a5_perr", bus.parity_err, 0);
    off = last_tick_cyc - frame_start;
    chk("a5_mid_stop", int'(off >= MID_STOP - 8 && off <= MID_STOP + 12), 1);

    // 3-tick low glitch on idle line
    base = done_cnt;
    bus.rx = 1'b0;
    repeat (12) @(negedge clk);
    idle_bits(3);
    chk("glitch_ticks", done_cnt - base, 0);
    chk("glitch_dout", bus.dout, 8'hA5);

    // framing error then recovery
    base = done_cnt;
    send_frame(8'h3C, 1'b0, ^8'h3C);
    idle_bits(1);
    chk("ferr_ticks", done_cnt - base, 1);
    chk("ferr_dout", bus.dout, 8'h3C);
    chk("ferr_flag", bus.frame_err, 1);
    send_frame(8'h55, 1'b1, ^8'h55);
    idle_bits(1);
    chk("rec_ticks", done_cnt - base, 2);
    chk("rec_dout", bus.dout, 8'h55);
    chk("rec_ferr", bus.frame_err, 0);

    // back-to-back frames, no idle between
    rec_q.delete();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0);
    idle_bits(1);
    chk("b2b_count", rec_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      got = (i < rec_q.size()) ? int'(rec_q[i]) : -1;
      chk($sformatf("b2b_dout%0d", i), got, exp_b2b[i]);
    end

`ifdef UART_RX_PARITY_EN
    // even parity: 0x07 has three ones, so parity bit 1 is correct
    send_frame(8'h07, 1'b1, 1'b1);
    idle_bits(1);
    chk("par_ok_dout", bus.dout, 8'h07);
    chk("par_ok_perr", bus.parity_err, 0);
    send_frame(8'h07, 1'b1, 1'b0);
    idle_bits(1);
    chk("par_bad_perr", bus.parity_err, 1);
`endif

    // reset in the middle of data bit 3 of 0x12
    bus.rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    bus.rx = 1'b0; repeat (BIT_CLK) @(negedge clk);
    bus.rx = 1'b1; repeat (BIT_CLK) @(negedge clk);
    bus.rx = 1'b0; repeat (BIT_CLK) @(negedge clk);
    bus.rx = 1'b0; repeat (24) @(negedge clk);
    reset_n = 1'b0;
    bus.rx  = 1'b1;
    repeat (3) @(negedge clk);
    chk("mrst_dout", bus.dout, 8'h00);
    chk("mrst_tick", bus.rx_done_tick, 0);
    chk("mrst_ferr", bus.frame_err, 0);
    chk("mrst_perr", bus.parity_err, 0);
    base = done_cnt;
    reset_n = 1'b1;
    idle_bits(2);
    chk("mrst_noticks", done_cnt - base, 0);
    send_frame(8'h12, 1'b1, ^8'h12);
    idle_bits(1);
    chk("post_rst_ticks", done_cnt - base, 1);
    chk("post_rst_dout", bus.dout, 8'h12);
    chk("post_rst_ferr", bus.frame_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
